// File: rtl/axis_vec_tx.sv
// axis_vec_tx: sends a VEC_LEN-word vector from a local bank as an AXI-Stream
// packet, then collects up to RES_LEN result words into a result bank.
//
// Optional feature macro: AXIS_VEC_TX_TIMER_EN adds the 'cycles' latency counter.
//
// Ports:
//   aclk, aresetn                 clock, synchronous active-low reset
//   vec_wr_en/addr/data           vector bank write (honoured only when not busy)
//   start                         single-cycle transaction request
//   busy, done, err_len           transaction status (registered)
//   res_rd_addr, res_rd_data      combinational result bank read
//   OUTPUT_AXIS_*                 vector stream master
//   INPUT_AXIS_*                  result stream slave
//   cycles                        transaction latency (AXIS_VEC_TX_TIMER_EN only)
module axis_vec_tx #(
    parameter int unsigned VEC_LEN = 4,
    parameter int unsigned RES_LEN = 4,
    localparam int unsigned VA_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1,
    localparam int unsigned RA_W = (RES_LEN > 1) ? $clog2(RES_LEN) : 1
) (
    input  logic            aclk,
    input  logic            aresetn,
    input  logic            vec_wr_en,
    input  logic [VA_W-1:0] vec_wr_addr,
    input  logic [31:0]     vec_wr_data,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            err_len,
    input  logic [RA_W-1:0] res_rd_addr,
    output logic [31:0]     res_rd_data,
`ifdef AXIS_VEC_TX_TIMER_EN
    output logic [31:0]     cycles,
`endif
    output logic [31:0]     OUTPUT_AXIS_TDATA,
    output logic            OUTPUT_AXIS_TLAST,
    output logic            OUTPUT_AXIS_TVALID,
    input  logic            OUTPUT_AXIS_TREADY,
    input  logic [31:0]     INPUT_AXIS_TDATA,
    input  logic            INPUT_AXIS_TLAST,
    input  logic            INPUT_AXIS_TVALID,
    output logic            INPUT_AXIS_TREADY
);

    // Result counter saturates at RES_LEN, so it needs one extra code point.
    localparam int unsigned CW = $clog2(RES_LEN + 1);
    localparam logic [VA_W-1:0] IDX_LAST = VA_W'(VEC_LEN - 1);
    localparam logic [CW-1:0]   RES_MAX  = CW'(RES_LEN);
    localparam logic [CW-1:0]   RES_LAST = CW'(RES_LEN - 1);

    typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;

    state_t          state_q, state_d;
    logic [VA_W-1:0] idx_q, idx_d;
    logic [CW-1:0]   rcnt_q, rcnt_d;
    logic            err_d;
    logic            tx_fire, rx_fire;
    logic            idle_like, bank_wr, res_wr;
    logic [31:0]     tdata_d;

    logic [31:0] vec_bank [VEC_LEN];
    logic [31:0] res_bank [RES_LEN];

    assign idle_like = (state_q == IDLE) || (state_q == DONE);
    assign tx_fire   = OUTPUT_AXIS_TVALID & OUTPUT_AXIS_TREADY;
    assign rx_fire   = INPUT_AXIS_TVALID & INPUT_AXIS_TREADY;
    assign bank_wr   = vec_wr_en & idle_like;
    assign res_wr    = rx_fire & (rcnt_q != RES_MAX);

    // Bypass a same-cycle bank write so the first beat after start sees it.
    assign tdata_d = (bank_wr && (vec_wr_addr == idx_d)) ? vec_wr_data : vec_bank[idx_d];

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rcnt_d  = rcnt_q;
        err_d   = err_len;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = SEND;
                    idx_d   = '0;
                    rcnt_d  = '0;
                    err_d   = 1'b0;
                end
            end
            SEND: begin
                if (tx_fire) begin
                    if (idx_q == IDX_LAST) state_d = RECV;
                    else                   idx_d   = idx_q + VA_W'(1);
                end
            end
            RECV: begin
                if (rx_fire) begin
                    // Beats beyond RES_LEN are dropped and flag a length error.
                    if (rcnt_q != RES_MAX) rcnt_d = rcnt_q + CW'(1);
                    else                   err_d  = 1'b1;
                    if (INPUT_AXIS_TLAST) begin
                        state_d = DONE;
                        if (rcnt_q != RES_LAST) err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs, all derived from the next state.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q            <= IDLE;
            idx_q              <= '0;
            rcnt_q             <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            err_len            <= 1'b0;
            OUTPUT_AXIS_TVALID <= 1'b0;
            OUTPUT_AXIS_TLAST  <= 1'b0;
            OUTPUT_AXIS_TDATA  <= '0;
            INPUT_AXIS_TREADY  <= 1'b0;
        end else begin
            state_q            <= state_d;
            idx_q              <= idx_d;
            rcnt_q             <= rcnt_d;
            err_len            <= err_d;
            busy               <= (state_d == SEND) || (state_d == RECV);
            done               <= (state_d == DONE);
            OUTPUT_AXIS_TVALID <= (state_d == SEND);
            INPUT_AXIS_TREADY  <= (state_d == RECV);
            if (state_d == SEND) begin
                OUTPUT_AXIS_TDATA <= tdata_d;
                OUTPUT_AXIS_TLAST <= (idx_d == IDX_LAST);
            end else begin
                OUTPUT_AXIS_TLAST <= 1'b0;
            end
        end
    end

    // Storage banks keep their contents across reset.
    always_ff @(posedge aclk) begin
        if (bank_wr) vec_bank[vec_wr_addr] <= vec_wr_data;
        if (res_wr)  res_bank[RA_W'(rcnt_q)] <= INPUT_AXIS_TDATA;
    end

    assign res_rd_data = res_bank[res_rd_addr];

`ifdef AXIS_VEC_TX_TIMER_EN
    // Latency counter: cleared by an accepted start, counts SEND/RECV cycles, saturates.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            cycles <= '0;
        end else if (idle_like && start) begin
            cycles <= '0;
        end else if (!idle_like && (cycles != 32'hFFFF_FFFF)) begin
            cycles <= cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axis_vec_tx.sv
// Self-checking bench for axis_vec_tx: scenario tasks with a beat scoreboard.
module tb_axis_vec_tx;
    localparam int unsigned VEC_LEN = 4;
    localparam int unsigned RES_LEN = 4;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        vec_wr_en;
    logic [1:0]  vec_wr_addr;
    logic [31:0] vec_wr_data;
    logic        start;
    logic        busy, done, err_len;
    logic [1:0]  res_rd_addr;
    logic [31:0] res_rd_data;
`ifdef AXIS_VEC_TX_TIMER_EN
    logic [31:0] cycles;
`endif
    logic [31:0] OUTPUT_AXIS_TDATA;
    logic        OUTPUT_AXIS_TLAST, OUTPUT_AXIS_TVALID, OUTPUT_AXIS_TREADY;
    logic [31:0] INPUT_AXIS_TDATA;
    logic        INPUT_AXIS_TLAST, INPUT_AXIS_TVALID, INPUT_AXIS_TREADY;

    always #5 aclk = ~aclk;

    axis_vec_tx #(.VEC_LEN(VEC_LEN), .RES_LEN(RES_LEN)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .vec_wr_en(vec_wr_en), .vec_wr_addr(vec_wr_addr), .vec_wr_data(vec_wr_data),
        .start(start), .busy(busy), .done(done), .err_len(err_len),
        .res_rd_addr(res_rd_addr), .res_rd_data(res_rd_data),
`ifdef AXIS_VEC_TX_TIMER_EN
        .cycles(cycles),
`endif
        .OUTPUT_AXIS_TDATA(OUTPUT_AXIS_TDATA), .OUTPUT_AXIS_TLAST(OUTPUT_AXIS_TLAST),
        .OUTPUT_AXIS_TVALID(OUTPUT_AXIS_TVALID), .OUTPUT_AXIS_TREADY(OUTPUT_AXIS_TREADY),
        .INPUT_AXIS_TDATA(INPUT_AXIS_TDATA), .INPUT_AXIS_TLAST(INPUT_AXIS_TLAST),
        .INPUT_AXIS_TVALID(INPUT_AXIS_TVALID), .INPUT_AXIS_TREADY(INPUT_AXIS_TREADY)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] vec_model [VEC_LEN];
    logic [31:0] res_model [RES_LEN];
    logic [31:0] exp_data_q[$];
    logic        exp_last_q[$];
    logic [31:0] obs_data_q[$];
    logic        obs_last_q[$];
    logic [31:0] rx_words[$];
    int          stall_viol, timeouts, send_cycles;
    logic        start_valid, start_busy, start_done, start_err;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic write_vec(input int addr, input logic [31:0] data);
        vec_wr_addr = 2'(addr);
        vec_wr_data = data;
        vec_wr_en   = 1'b1;
        tick();
        vec_wr_en   = 1'b0;
        vec_model[addr] = data;
    endtask

    // Runs one transaction: mode 0 ready always, 1 alternating ready (0 first),
    // 2 alternating ready while hammering start and bank writes.
    task automatic run_txn(input int mode);
        int          k, j;
        bit          last_seen, rx_done, stalled;
        logic [31:0] held_d;
        logic        held_l;
        stall_viol = 0;
        send_cycles = 0;
        obs_data_q.delete();
        obs_last_q.delete();
        for (int i = 0; i < int'(VEC_LEN); i++) begin
            exp_data_q.push_back(vec_model[i]);
            exp_last_q.push_back(i == int'(VEC_LEN) - 1);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        start_valid = OUTPUT_AXIS_TVALID;
        start_busy  = busy;
        start_done  = done;
        start_err   = err_len;
        k = 0; stalled = 0; last_seen = 0; held_d = '0; held_l = 1'b0;
        while (!last_seen && k < 100) begin
            OUTPUT_AXIS_TREADY = (mode == 0) ? 1'b1 : 1'(k % 2);
            if (mode == 2) begin
                start = 1'b1; vec_wr_en = 1'b1;
                vec_wr_addr = 2'(k % int'(VEC_LEN)); vec_wr_data = 32'hDEAD_0000 | 32'(k);
            end
            if (stalled && (OUTPUT_AXIS_TDATA !== held_d || OUTPUT_AXIS_TLAST !== held_l ||
                            OUTPUT_AXIS_TVALID !== 1'b1))
                stall_viol++;
            if (OUTPUT_AXIS_TVALID && OUTPUT_AXIS_TREADY) begin
                obs_data_q.push_back(OUTPUT_AXIS_TDATA);
                obs_last_q.push_back(OUTPUT_AXIS_TLAST);
                last_seen = OUTPUT_AXIS_TLAST;
                stalled = 0;
            end else if (OUTPUT_AXIS_TVALID) begin
                stalled = 1; held_d = OUTPUT_AXIS_TDATA; held_l = OUTPUT_AXIS_TLAST;
            end
            send_cycles++; k++;
            tick();
        end
        if (!last_seen) timeouts++;
        OUTPUT_AXIS_TREADY = 1'b0;
        k = 0; j = 0; rx_done = 0;
        while (!rx_done && k < 100) begin
            if (mode == 2) begin
                start = 1'b1; vec_wr_en = 1'b1;
                vec_wr_addr = 2'(k % int'(VEC_LEN)); vec_wr_data = 32'hBEEF_0000 | 32'(k);
            end
            if (j < rx_words.size()) begin
                INPUT_AXIS_TVALID = 1'b1;
                INPUT_AXIS_TDATA  = rx_words[j];
                INPUT_AXIS_TLAST  = (j == rx_words.size() - 1);
            end
            if (INPUT_AXIS_TVALID && INPUT_AXIS_TREADY) begin
                if (j < int'(RES_LEN)) res_model[j] = rx_words[j];
                if (INPUT_AXIS_TLAST) rx_done = 1;
                j++;
            end
            k++;
            tick();
            INPUT_AXIS_TVALID = 1'b0;
            INPUT_AXIS_TLAST  = 1'b0;
        end
        start = 1'b0;
        vec_wr_en = 1'b0;
        if (!rx_done) timeouts++;
    endtask

    task automatic test_reset();
        aresetn = 1'b0; vec_wr_en = 1'b0; vec_wr_addr = '0; vec_wr_data = '0; start = 1'b0;
        res_rd_addr = '0; OUTPUT_AXIS_TREADY = 1'b0; INPUT_AXIS_TDATA = '0;
        INPUT_AXIS_TLAST = 1'b0; INPUT_AXIS_TVALID = 1'b0; timeouts = 0;
        repeat (20) tick();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (err_len !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", err_len); end
        n_cmp++; if (OUTPUT_AXIS_TVALID !== 1'b0) begin n_err++; $display("FAIL reset_tvalid: got %b want 0", OUTPUT_AXIS_TVALID); end
        n_cmp++; if (OUTPUT_AXIS_TLAST !== 1'b0) begin n_err++; $display("FAIL reset_tlast: got %b want 0", OUTPUT_AXIS_TLAST); end
        n_cmp++; if (OUTPUT_AXIS_TDATA !== 32'h0) begin n_err++; $display("FAIL reset_tdata: got %h want 0", OUTPUT_AXIS_TDATA); end
        n_cmp++; if (INPUT_AXIS_TREADY !== 1'b0) begin n_err++; $display("FAIL reset_tready: got %b want 0", INPUT_AXIS_TREADY); end
`ifdef AXIS_VEC_TX_TIMER_EN
        n_cmp++; if (cycles !== 32'h0) begin n_err++; $display("FAIL reset_cycles: got %0d want 0", cycles); end
`endif
        aresetn = 1'b1;
        tick();
    endtask

    task automatic check_beats(input string name);
        n_cmp++;
        if (obs_data_q.size() != exp_data_q.size()) begin
            n_err++; $display("FAIL %s_count: got %0d want %0d", name, obs_data_q.size(), exp_data_q.size());
        end
        while (obs_data_q.size() > 0 && exp_data_q.size() > 0) begin
            logic [31:0] od, ed;
            logic        ol, el;
            od = obs_data_q.pop_front(); ed = exp_data_q.pop_front();
            ol = obs_last_q.pop_front(); el = exp_last_q.pop_front();
            n_cmp++;
            if (od !== ed || ol !== el) begin
                n_err++; $display("FAIL %s_beat: got %h/%b want %h/%b", name, od, ol, ed, el);
            end
        end
        exp_data_q.delete(); exp_last_q.delete();
    endtask

    task automatic test_nominal();
        write_vec(0, 32'h3DCCCCCD); write_vec(1, 32'h3E4CCCCD);
        write_vec(2, 32'h3E99999A); write_vec(3, 32'h3ECCCCCD);
        rx_words = '{32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000};
        run_txn(0);
        n_cmp++; if (start_valid !== 1'b1) begin n_err++; $display("FAIL nom_first_valid: got %b want 1", start_valid); end
        n_cmp++; if (send_cycles != 4) begin n_err++; $display("FAIL nom_send_cycles: got %0d want 4", send_cycles); end
        check_beats("nom");
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL nom_done: got %b want 1", done); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL nom_busy: got %b want 0", busy); end
        n_cmp++; if (err_len !== 1'b0) begin n_err++; $display("FAIL nom_err: got %b want 0", err_len); end
        n_cmp++; if (OUTPUT_AXIS_TVALID !== 1'b0 || INPUT_AXIS_TREADY !== 1'b0) begin
            n_err++; $display("FAIL nom_idle_stream: got %b%b want 00", OUTPUT_AXIS_TVALID, INPUT_AXIS_TREADY); end
        for (int i = 0; i < int'(RES_LEN); i++) begin
            res_rd_addr = 2'(i); #1;
            n_cmp++; if (res_rd_data !== res_model[i]) begin n_err++; $display("FAIL nom_res%0d: got %h want %h", i, res_rd_data, res_model[i]); end
        end
`ifdef AXIS_VEC_TX_TIMER_EN
        n_cmp++; if (cycles !== 32'd8) begin n_err++; $display("FAIL nom_cycles: got %0d want 8", cycles); end
`endif
    endtask

    task automatic test_backpressure();
        rx_words = '{32'hC0000001, 32'hC0000002, 32'hC0000003, 32'hC0000004};
        run_txn(1);
        n_cmp++; if (stall_viol != 0) begin n_err++; $display("FAIL bp_stable: got %0d violations want 0", stall_viol); end
        check_beats("bp");
        n_cmp++; if (done !== 1'b1 || err_len !== 1'b0) begin n_err++; $display("FAIL bp_status: got done=%b err=%b want 1/0", done, err_len); end
`ifdef AXIS_VEC_TX_TIMER_EN
        n_cmp++; if (cycles !== 32'd12) begin n_err++; $display("FAIL bp_cycles: got %0d want 12", cycles); end
`endif
    endtask

    task automatic test_short_result();
        rx_words = '{32'h11111111, 32'h22222222, 32'h33333333};
        run_txn(0);
        check_beats("short");
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL short_done: got %b want 1", done); end
        n_cmp++; if (err_len !== 1'b1) begin n_err++; $display("FAIL short_err: got %b want 1", err_len); end
        for (int i = 0; i < int'(RES_LEN); i++) begin
            res_rd_addr = 2'(i); #1;
            n_cmp++; if (res_rd_data !== res_model[i]) begin n_err++; $display("FAIL short_res%0d: got %h want %h", i, res_rd_data, res_model[i]); end
        end
    endtask

    task automatic test_long_result();
        rx_words = '{32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5};
        run_txn(0);
        check_beats("long");
        n_cmp++; if (err_len !== 1'b1 || done !== 1'b1) begin n_err++; $display("FAIL long_status: got err=%b done=%b want 1/1", err_len, done); end
        for (int i = 0; i < int'(RES_LEN); i++) begin
            res_rd_addr = 2'(i); #1;
            n_cmp++; if (res_rd_data !== res_model[i]) begin n_err++; $display("FAIL long_res%0d: got %h want %h", i, res_rd_data, res_model[i]); end
        end
    endtask

    task automatic test_back_to_back();
        rx_words = '{32'hB1, 32'hB2, 32'hB3, 32'hB4};
        run_txn(0);
        n_cmp++; if (start_busy !== 1'b1 || start_done !== 1'b0 || start_err !== 1'b0) begin
            n_err++; $display("FAIL b2b_start: got busy=%b done=%b err=%b want 1/0/0", start_busy, start_done, start_err); end
        check_beats("b2b");
        n_cmp++; if (err_len !== 1'b0) begin n_err++; $display("FAIL b2b_err: got %b want 0", err_len); end
    endtask

    task automatic test_reset_mid_send();
        start = 1'b1; tick(); start = 1'b0;
        OUTPUT_AXIS_TREADY = 1'b1;
        tick(); tick();
        n_cmp++; if (OUTPUT_AXIS_TDATA !== vec_model[2]) begin n_err++; $display("FAIL rst_mid_pre: got %h want %h", OUTPUT_AXIS_TDATA, vec_model[2]); end
        aresetn = 1'b0;
        tick();
        n_cmp++; if (OUTPUT_AXIS_TVALID !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL rst_mid_abort: got tvalid=%b busy=%b want 0/0", OUTPUT_AXIS_TVALID, busy); end
        aresetn = 1'b1; OUTPUT_AXIS_TREADY = 1'b0;
        tick();
        rx_words = '{32'hD1, 32'hD2, 32'hD3, 32'hD4};
        run_txn(0);
        check_beats("rst_mid");
        n_cmp++; if (done !== 1'b1 || err_len !== 1'b0) begin n_err++; $display("FAIL rst_mid_status: got done=%b err=%b want 1/0", done, err_len); end
    endtask

    task automatic test_ignored_inputs();
        rx_words = '{32'hE1, 32'hE2, 32'hE3, 32'hE4};
        run_txn(2);
        check_beats("ign");
        n_cmp++; if (done !== 1'b1 || err_len !== 1'b0) begin n_err++; $display("FAIL ign_status: got done=%b err=%b want 1/0", done, err_len); end
`ifdef AXIS_VEC_TX_TIMER_EN
        n_cmp++; if (cycles !== 32'd12) begin n_err++; $display("FAIL ign_cycles: got %0d want 12", cycles); end
`endif
        run_txn(0);
        check_beats("ign_bank");
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_short_result();
        test_long_result();
        test_back_to_back();
        test_reset_mid_send();
        test_ignored_inputs();
        n_cmp++; if (timeouts != 0) begin n_err++; $display("FAIL timeouts: got %0d want 0", timeouts); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
